// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file: clear engine
// state encoding and the default bank geometry used by the datapath.
package regfile_pkg;

  localparam int RF_DWIDTH = 16;
  localparam int RF_AWIDTH = 5;
  localparam int RF_NRD    = 2;

  typedef enum logic {
    RF_IDLE     = 1'b0,
    RF_CLEARING = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port of regfile_mp: selects bank data, applies the
// write bypass when built with REGFILE_BYPASS_EN, masks r0 and registers
// the result together with a one-cycle read-valid flag.
module regfile_rdport #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic              rd_req,
  input  logic [DWIDTH-1:0] bank_data,
  input  logic              wr_ok,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  logic [DWIDTH-1:0] next_data;

  // Pick the value this port would capture: bank content, optionally the
  // in-flight write, and always zero for r0 when it is hardwired.
  always_comb begin
    next_data = bank_data;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr)) begin
      next_data = wr_data;
    end
`else
    if (wr_ok && (wr_addr == rd_addr)) begin
      next_data = bank_data;
    end
`endif
    if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
      next_data = '0;
    end
  end

  // Capture data only for accepted requests; otherwise hold data, drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_req && !busy) begin
      rd_data  <= next_data;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the myMIPS datapath: NRD registered
// read ports, one write port, hardwired-zero r0 and a sequential clear
// engine that zeroes one entry per cycle after reset and on request.
// Build option: define REGFILE_BYPASS_EN for write-first read behaviour.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DWIDTH  = RF_DWIDTH,
  parameter int AWIDTH  = RF_AWIDTH,
  parameter int NRD     = RF_NRD,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NRD*AWIDTH-1:0] rd_addr,
  input  logic [NRD-1:0]        rd_req,
  output logic [NRD*DWIDTH-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic                  wr_req,
  input  logic [DWIDTH-1:0]     wr_data,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  rf_state_e         state_q;
  rf_state_e         state_d;
  logic [AWIDTH-1:0] clr_cnt;
  logic [DWIDTH-1:0] bank [DEPTH];
  logic              wr_ok;

  assign busy  = (state_q == RF_CLEARING);
  assign wr_ok = wr_req && !busy && !((ZERO_R0 != 0) && (wr_addr == '0));

  // Clear engine next state: leave IDLE on request, return after last entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_IDLE:     if (clear) state_d = RF_CLEARING;
      RF_CLEARING: if (clr_cnt == LAST_IDX) state_d = RF_IDLE;
      default:     state_d = RF_IDLE;
    endcase
  end

  // State register and clear pointer; reset starts a full clear from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEARING;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= busy ? clr_cnt + 1'b1 : '0;
    end
  end

  // Flag writes that arrive while the bank is being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_req && busy;
    end
  end

  // Bank storage: the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      bank[clr_cnt] <= '0;
    end else if (wr_ok) begin
      bank[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rdport
    logic [DWIDTH-1:0] bank_rd;
    assign bank_rd = bank[rd_addr[k*AWIDTH +: AWIDTH]];

    regfile_rdport #(
      .DWIDTH  (DWIDTH),
      .AWIDTH  (AWIDTH),
      .ZERO_R0 (ZERO_R0)
    ) u_rdport (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy),
      .rd_addr   (rd_addr[k*AWIDTH +: AWIDTH]),
      .rd_req    (rd_req[k]),
      .bank_data (bank_rd),
      .wr_ok     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[k*DWIDTH +: DWIDTH]),
      .rd_valid  (rd_valid[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DWIDTH=16, AWIDTH=5, NRD=2,
// ZERO_R0=1). Expectations for same-cycle read/write follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_req;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic [4:0]  wr_addr;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        busy;
  logic        wr_drop;

  int checkCount = 0;
  int passCount  = 0;
  int n;

  regfile_mp #(
    .DWIDTH  (16),
    .AWIDTH  (5),
    .NRD     (2),
    .ZERO_R0 (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .rd_addr  (rd_addr),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_addr  (wr_addr),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] wa, input logic we, input logic [15:0] wd,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] rq);
    wr_addr = wa;
    wr_req  = we;
    wr_data = wd;
    rd_addr = {ra1, ra0};
    rd_req  = rq;
    tick();
    wr_req = 1'b0;
    rd_req = 2'b00;
  endtask

  task automatic waitIdle(input string tag);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, n, 32);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; rd_addr = '0; rd_req = '0;
    wr_addr = '0; wr_req = 1'b0; wr_data = '0;
    #1;
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_drop", wr_drop, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: initial clear then read addr 7
    waitIdle("init_clear_cycles");
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd7, 5'd0, 2'b01);
    checkOutput("rd7_data", rd_data[15:0], 16'h0000);
    checkOutput("rd7_valid", rd_valid, 2'b01);

    // 2: write then dual-port read
    applyStimulus(5'd3, 1'b1, 16'hBEEF, 5'd0, 5'd0, 2'b00);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd3, 5'd3, 2'b11);
    checkOutput("r3_port0", rd_data[15:0], 16'hBEEF);
    checkOutput("r3_port1", rd_data[31:16], 16'hBEEF);
    checkOutput("r3_valid", rd_valid, 2'b11);

    // idle port: valid drops, data holds
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd9, 5'd9, 2'b00);
    checkOutput("hold_valid", rd_valid, 2'b00);
    checkOutput("hold_data", rd_data, 32'hBEEF_BEEF);

    // 3: same-cycle write/read of r5
    applyStimulus(5'd5, 1'b1, 16'h1234, 5'd5, 5'd3, 2'b11);
`ifdef REGFILE_BYPASS_EN
    checkOutput("r5_same_cycle", rd_data[15:0], 16'h1234);
`else
    checkOutput("r5_same_cycle", rd_data[15:0], 16'h0000);
`endif
    checkOutput("r3_other_port", rd_data[31:16], 16'hBEEF);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd5, 5'd0, 2'b01);
    checkOutput("r5_next_read", rd_data[15:0], 16'h1234);

    // 4: r0 is hardwired zero, including a same-cycle write
    applyStimulus(5'd0, 1'b1, 16'hFFFF, 5'd0, 5'd0, 2'b00);
    checkOutput("r0_wr_drop", wr_drop, 0);
    applyStimulus(5'd0, 1'b1, 16'hFFFF, 5'd0, 5'd0, 2'b11);
    checkOutput("r0_read", rd_data, 32'h0);
    checkOutput("r0_valid", rd_valid, 2'b11);
    checkOutput("r0_wr_drop2", wr_drop, 0);

    // 5: fill r1..r31, clear, write while busy, clear re-request ignored
    for (int a = 1; a < 32; a++) applyStimulus(5'(a), 1'b1, 16'hA5A5, 5'd0, 5'd0, 2'b00);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd31, 5'd1, 2'b11);
    checkOutput("fill_read", rd_data, 32'hA5A5_A5A5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear_busy", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      wr_req  = (n == 1);
      wr_addr = 5'd6;
      wr_data = 16'h6666;
      clear   = (n == 5);
      rd_req  = (n == 3) ? 2'b11 : 2'b00;
      tick();
      n++;
      if (n == 2) checkOutput("busy_wr_drop", wr_drop, 1);
      if (n == 3) checkOutput("wr_drop_pulse", wr_drop, 0);
      if (n == 4) checkOutput("busy_rd_valid", rd_valid, 2'b00);
    end
    wr_req = 1'b0; clear = 1'b0; rd_req = 2'b00;
    checkOutput("clear_cycles", n, 32);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd1, 5'd31, 2'b11);
    checkOutput("cleared_r1_r31", rd_data, 32'h0);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd6, 5'd3, 2'b11);
    checkOutput("cleared_r6_r3", rd_data, 32'h0);

    // 6: reset in the middle of a clear
    applyStimulus(5'd4, 1'b1, 16'h4444, 5'd0, 5'd0, 2'b00);
    applyStimulus(5'd20, 1'b1, 16'h2020, 5'd0, 5'd0, 2'b00);
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd4, 5'd20, 2'b11);
    checkOutput("pre_rst_read", rd_data, 32'h2020_4444);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_req = (i == 9);
      tick();
    end
    wr_req = 1'b0;
    checkOutput("mid_clear_wr_drop", wr_drop, 1);
    checkOutput("mid_clear_hold", rd_data, 32'h2020_4444);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_data", rd_data, 32'h0);
    checkOutput("async_rst_wr_drop", wr_drop, 0);
    checkOutput("async_rst_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    waitIdle("restart_clear_cycles");
    applyStimulus(5'd0, 1'b0, 16'h0, 5'd4, 5'd20, 2'b11);
    checkOutput("post_rst_r4_r20", rd_data, 32'h0);
    checkOutput("post_rst_valid", rd_valid, 2'b11);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
